// File: rtl/pool_pkg.sv
// Shared types and constants for the 2x2 max-pool read sequencer.
// Optional runtime map size: POOL_CTRL_RT_SIZE_EN.
package pool_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int DEF_MAP_W = 28;
  localparam int DEF_MAP_H = 28;
  localparam int RD_LAT    = 1;

endpackage

// File: rtl/pool_addr_gen.sv
// Window / row / column counters producing the row-major read address
// stream for 2x2 windows, four reads per window.
module pool_addr_gen #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_adv,
  input  logic [7:0]        i_w,
  input  logic [7:0]        i_h,
  output logic [ADDR_W-1:0] o_addr,
  output logic [1:0]        o_q,
  output logic [ADDR_W-1:0] o_win,
  output logic              o_last
);

  logic [1:0]        r_q;
  logic [6:0]        r_i;
  logic [6:0]        r_j;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_win;

  logic [6:0]        w_hw;
  logic [6:0]        w_hh;
  logic              w_jend;
  logic              w_iend;
  logic [ADDR_W-1:0] w_wext;

  assign w_hw   = i_w[7:1];
  assign w_hh   = i_h[7:1];
  assign w_jend = (r_j == w_hw - 7'd1);
  assign w_iend = (r_i == w_hh - 7'd1);
  assign w_wext = ADDR_W'(i_w);

  // r_base tracks (2i)*W so no multiplier is needed
  assign o_addr = r_base
                + (r_q[1] ? w_wext : '0)
                + ADDR_W'({r_j, 1'b0})
                + ADDR_W'(r_q[0]);
  assign o_q    = r_q;
  assign o_win  = r_win;
  assign o_last = (r_q == 2'd3) && w_jend && w_iend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      r_i    <= '0;
      r_j    <= '0;
      r_base <= '0;
      r_win  <= '0;
    end else if (i_adv) begin
      r_q <= r_q + 2'd1;
      if (r_q == 2'd3) begin
        r_win <= o_last ? '0 : r_win + 1'b1;
        if (w_jend) begin
          r_j <= '0;
          if (w_iend) begin
            r_i    <= '0;
            r_base <= '0;
          end else begin
            r_i    <= r_i + 7'd1;
            r_base <= r_base + w_wext + w_wext;
          end
        end else begin
          r_j <= r_j + 7'd1;
        end
      end
    end
  end

endmodule

// File: rtl/pool_ctrl.sv
// 2x2 max-pool pass controller: FSM plus clear/valid delay pipeline.
// Define POOL_CTRL_RT_SIZE_EN to add runtime cfg_w/cfg_h map size inputs.
module pool_ctrl
  import pool_pkg::*;
#(
  parameter int MAP_W  = DEF_MAP_W,
  parameter int MAP_H  = DEF_MAP_H,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef POOL_CTRL_RT_SIZE_EN
  input  logic [7:0]        cfg_w,
  input  logic [7:0]        cfg_h,
`endif
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              pool_clr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr
);

  state_t r_state;
  state_t w_next;

  logic [7:0]        w_w;
  logic [7:0]        w_h;
  logic [ADDR_W-1:0] w_addr;
  logic [1:0]        w_q;
  logic [ADDR_W-1:0] w_win;
  logic              w_last;
  logic              w_run;

  logic              r_clr;
  logic              r_last_d;
  logic              r_ov;
  logic [ADDR_W-1:0] r_win_d;
  logic [ADDR_W-1:0] r_oaddr;

`ifdef POOL_CTRL_RT_SIZE_EN
  logic [7:0] r_w;
  logic [7:0] r_h;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w <= 8'(MAP_W);
      r_h <= 8'(MAP_H);
    end else if (r_state == S_IDLE && start) begin
      r_w <= cfg_w;
      r_h <= cfg_h;
    end
  end

  assign w_w = r_w;
  assign w_h = r_h;
`else
  assign w_w = 8'(MAP_W);
  assign w_h = 8'(MAP_H);
`endif

  assign w_run = (r_state == S_RUN);

  pool_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_adv  (w_run),
    .i_w    (w_w),
    .i_h    (w_h),
    .o_addr (w_addr),
    .o_q    (w_q),
    .o_win  (w_win),
    .o_last (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start)  w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DRAIN;
      S_DRAIN: if (r_ov)   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // one stage covers buffer latency, the second the pool unit's register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr    <= 1'b0;
      r_last_d <= 1'b0;
      r_ov     <= 1'b0;
      r_win_d  <= '0;
      r_oaddr  <= '0;
    end else begin
      r_clr    <= w_run && (w_q == 2'd0);
      r_last_d <= w_run && (w_q == 2'd3);
      r_ov     <= r_last_d;
      r_win_d  <= w_win;
      r_oaddr  <= r_win_d;
    end
  end

  assign busy      = w_run || (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);
  assign rd_en     = w_run;
  assign rd_addr   = w_run ? w_addr : '0;
  assign pool_clr  = r_clr;
  assign out_valid = r_ov;
  assign out_addr  = r_oaddr;

endmodule

// File: tb/tb_pool_ctrl.sv
// Bench for pool_ctrl: 4x4 and 28x28 instances, buffer and max unit models.
module tb_pool_ctrl;

  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic sel = 1'b0;
  logic start_d = 1'b0;

  logic s4, b4, d4, re4, pc4, ov4;
  logic s28, b28, d28, re28, pc28, ov28;
  logic [AW-1:0] ra4, oa4, ra28, oa28;

  assign s4  = start_d & ~sel;
  assign s28 = start_d & sel;

`ifdef POOL_CTRL_RT_SIZE_EN
  logic [7:0] cw4 = 8'd4, ch4 = 8'd4, cw28 = 8'd28, ch28 = 8'd28;
`endif

  pool_ctrl #(.MAP_W(4), .MAP_H(4), .ADDR_W(AW)) dut4 (
    .clk(clk), .rst_n(rst_n),
`ifdef POOL_CTRL_RT_SIZE_EN
    .cfg_w(cw4), .cfg_h(ch4),
`endif
    .start(s4), .busy(b4), .done(d4), .rd_en(re4), .rd_addr(ra4),
    .pool_clr(pc4), .out_valid(ov4), .out_addr(oa4));

  pool_ctrl #(.ADDR_W(AW)) dut28 (
    .clk(clk), .rst_n(rst_n),
`ifdef POOL_CTRL_RT_SIZE_EN
    .cfg_w(cw28), .cfg_h(ch28),
`endif
    .start(s28), .busy(b28), .done(d28), .rd_en(re28), .rd_addr(ra28),
    .pool_clr(pc28), .out_valid(ov28), .out_addr(oa28));

  logic m_busy, m_done, m_re, m_pc, m_ov;
  logic [AW-1:0] m_ra, m_oa;
  assign m_busy = sel ? b28 : b4;
  assign m_done = sel ? d28 : d4;
  assign m_re   = sel ? re28 : re4;
  assign m_pc   = sel ? pc28 : pc4;
  assign m_ov   = sel ? ov28 : ov4;
  assign m_ra   = sel ? ra28 : ra4;
  assign m_oa   = sel ? oa28 : oa4;

  // feature-map buffer (1-cycle latency) and max-pool unit
  logic [7:0] mem [1024];
  logic [7:0] rdata = 8'd0;
  logic [7:0] maxr = 8'd0;
  always @(posedge clk) begin
    if (m_re) rdata <= mem[m_ra];
    if (m_pc) maxr <= rdata;
    else if (rdata > maxr) maxr <= rdata;
  end

  int errs = 0;
  int checks = 0;
  int q_addr[$];
  int q_max[$];

  task automatic fill(input bit ident);
    for (int a = 0; a < 1024; a++)
      mem[a] = ident ? 8'(a) : 8'($urandom_range(0, 255));
  endtask

  function automatic int pix_addr(input int W, input int k, input int q);
    int i, j;
    i = k / (W / 2);
    j = k % (W / 2);
    return (2 * i + q / 2) * W + 2 * j + q % 2;
  endfunction

  function automatic int win_max(input int W, input int k);
    int m = 0;
    for (int q = 0; q < 4; q++)
      if (int'(mem[pix_addr(W, k, q)]) > m) m = int'(mem[pix_addr(W, k, q)]);
    return m;
  endfunction

  task automatic run_pass(input int W, input int H, input int xs1,
                          input int xs2, input int rst_at);
    int n, last, nre, nov, ndone, bad;
    logic [4:0] ev, ob;
    n = (W / 2) * (H / 2);
    last = 4 * n + 6;
    nre = 0; nov = 0; ndone = 0;
    q_addr.delete();
    q_max.delete();
`ifdef POOL_CTRL_RT_SIZE_EN
    if (sel) begin cw28 = W[7:0]; ch28 = H[7:0]; end
    else     begin cw4 = W[7:0];  ch4 = H[7:0];  end
`endif
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    start_d = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      start_d = (c == xs1) || (c == xs2);
`ifdef POOL_CTRL_RT_SIZE_EN
      if (c == 3) begin
        cw28 = 8'($urandom_range(1, 15) * 2); ch28 = 8'($urandom_range(1, 15) * 2);
        cw4  = 8'($urandom_range(1, 15) * 2); ch4  = 8'($urandom_range(1, 15) * 2);
      end
`endif
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_busy, m_done, m_re, m_pc, m_ov, m_ra, m_oa} !== '0) begin
          errs++;
          $display("FAIL rst_outputs cyc=%0d got=%b/%0d/%0d exp=0", c,
                   {m_busy, m_done, m_re, m_pc, m_ov}, m_ra, m_oa);
        end
        start_d = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (800) begin
          @(negedge clk);
          if (m_done || m_ov || m_busy || m_re) bad++;
        end
        checks++;
        if (bad != 0) begin
          errs++;
          $display("FAIL post_rst_quiet activity_cycles=%0d exp=0", bad);
        end
        return;
      end
      ev[4] = (c <= 4 * n + 2);
      ev[3] = (c == 4 * n + 3);
      ev[2] = (c <= 4 * n);
      ev[1] = (c >= 2) && (c <= 4 * n + 1) && ((c - 2) % 4 == 0);
      ev[0] = (c >= 6) && (c <= 4 * n + 2) && ((c - 6) % 4 == 0);
      ob = {m_busy, m_done, m_re, m_pc, m_ov};
      checks++;
      if (ob !== ev) begin
        errs++;
        if (errs < 30)
          $display("FAIL ctl W=%0d H=%0d cyc=%0d got=%b exp=%b", W, H, c, ob, ev);
      end
      if (m_re) nre++;
      if (m_ov) nov++;
      if (m_done) ndone++;
      if (ev[2]) begin
        q_addr.push_back(int'(m_ra));
        checks++;
        if (int'(m_ra) !== pix_addr(W, (c - 1) / 4, (c - 1) % 4)) begin
          errs++;
          if (errs < 30)
            $display("FAIL rd_addr cyc=%0d got=%0d exp=%0d", c, m_ra,
                     pix_addr(W, (c - 1) / 4, (c - 1) % 4));
        end
      end
      if (ev[0]) begin
        q_max.push_back(int'(maxr));
        checks++;
        if (int'(m_oa) !== (c - 6) / 4 || int'(maxr) !== win_max(W, (c - 6) / 4)) begin
          errs++;
          if (errs < 30)
            $display("FAIL window cyc=%0d got=%0d/%0d exp=%0d/%0d", c, m_oa, maxr,
                     (c - 6) / 4, win_max(W, (c - 6) / 4));
        end
      end
    end
    start_d = 1'b0;
    checks++;
    if (nre != 4 * n || nov != n || ndone != 1) begin
      errs++;
      $display("FAIL counts rd=%0d ov=%0d done=%0d exp=%0d/%0d/1", nre, nov, ndone,
               4 * n, n);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({b4, d4, re4, pc4, ov4, ra4, oa4, b28, d28, re28, pc28, ov28, ra28, oa28} !== '0) begin
      errs++;
      $display("FAIL reset_state got=%b exp=0", {b4, d4, re4, pc4, ov4, b28, d28, re28, pc28, ov28});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_4x4_ident();
    int ea[16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
    int em[4] = '{5, 7, 13, 15};
    sel = 1'b0;
    fill(1'b1);
    run_pass(4, 4, -1, -1, -1);
    checks++;
    if (q_addr.size() != 16 || q_max.size() != 4) begin
      errs++;
      $display("FAIL seq_len got=%0d/%0d exp=16/4", q_addr.size(), q_max.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (q_addr[i] != ea[i]) begin
          errs++;
          $display("FAIL addr_tbl idx=%0d got=%0d exp=%0d", i, q_addr[i], ea[i]);
        end
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q_max[i] != em[i]) begin
          errs++;
          $display("FAIL max_tbl idx=%0d got=%0d exp=%0d", i, q_max[i], em[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    for (int p = 0; p < 6; p++) begin
      fill(1'b0);
      run_pass(4, 4, $urandom_range(2, 18), 19, -1);
    end
  endtask

  task automatic test_28x28();
    sel = 1'b1;
    fill(1'b0);
    run_pass(28, 28, 5, 787, -1);
  endtask

  task automatic test_midpass_reset();
    sel = 1'b1;
    fill(1'b0);
    run_pass(28, 28, -1, -1, 40);
    run_pass(28, 28, -1, -1, -1);
  endtask

`ifdef POOL_CTRL_RT_SIZE_EN
  task automatic test_rt_size();
    sel = 1'b1;
    fill(1'b0);
    run_pass(8, 6, -1, 51, -1);
    for (int p = 0; p < 4; p++)
      run_pass($urandom_range(1, 16) * 2, $urandom_range(1, 16) * 2, -1, -1, -1);
  endtask
`endif

  initial begin
    test_reset();
    test_4x4_ident();
    test_back_to_back();
    test_28x28();
    test_midpass_reset();
`ifdef POOL_CTRL_RT_SIZE_EN
    test_rt_size();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/pool_ctrl.md
POOL_CTRL -- requirements
Module: pool_ctrl

Interface
REQ-001 The block SHALL have parameter MAP_W, default 28, input feature-map width in pixels (even, 2..254).
REQ-002 The block SHALL have parameter MAP_H, default 28, input feature-map height in pixels (even, 2..254).
REQ-003 The block SHALL have parameter ADDR_W, default 10, width of the read and output address buses.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  one-cycle pulse that launches one pooling pass; ignored while busy=1.
REQ-007 busy  output  1  high while a pass is in progress.
REQ-008 done  output  1  one-cycle pulse at the end of a pass.
REQ-009 rd_en  output  1  read strobe to the feature-map buffer; the buffer has a fixed 1-cycle read latency.
REQ-010 rd_addr  output  ADDR_W  row-major pixel address, r*W+c.
REQ-011 pool_clr  output  1  drives the max-pool unit clear/load; high in the cycle the first pixel of a window arrives.
REQ-012 out_valid  output  1  high in the cycle the max-pool unit output holds a completed window maximum.
REQ-013 out_addr  output  ADDR_W  row-major index of the completed window, valid when out_valid=1.

Function
REQ-014 States SHALL be IDLE, RUN, DRAIN and DONE; the only transitions are IDLE->RUN on start, RUN->DRAIN after the last read, DRAIN->DONE after the last out_valid, and DONE->IDLE unconditionally.
REQ-015 Window count N SHALL be (W/2)*(H/2); windows SHALL be visited row-major over output positions.
REQ-016 Each window at output (i,j) SHALL issue exactly 4 reads in order (2i,2j), (2i,2j+1), (2i+1,2j), (2i+1,2j+1).
REQ-017 With start sampled at cycle 0, rd_en SHALL be high continuously for cycles 1..4N, with no bubbles between windows.
REQ-018 pool_clr SHALL be high in cycles 2+4k for k=0..N-1, and low otherwise.
REQ-019 out_valid SHALL be high in cycles 6+4k for k=0..N-1, with out_addr=k, coinciding with pool_clr of window k+1.
REQ-020 busy SHALL be high for cycles 1..4N+2; done SHALL pulse in cycle 4N+3, with busy low in that cycle.
REQ-021 A start arriving in the same cycle as done SHALL be ignored; the next pass starts only from IDLE.
REQ-022 Row/column counters SHALL wrap exactly at W/2 and H/2 with no out-of-range address, and address arithmetic SHALL be ADDR_W bits wide with no truncation for legal sizes.

Reset
REQ-023 rst_n low SHALL force state IDLE and all outputs (busy, done, rd_en, rd_addr, pool_clr, out_valid, out_addr) to 0 immediately, including mid-pass.
REQ-024 After a mid-pass reset, no done pulse and no out_valid SHALL be produced until a new start.

Configuration
REQ-025 With POOL_CTRL_RT_SIZE_EN defined, the block SHALL add inputs cfg_w and cfg_h (8 bits each), sample them when start is accepted, and use them as W and H for that pass.
REQ-026 Without POOL_CTRL_RT_SIZE_EN, cfg_w and cfg_h SHALL NOT exist, and W=MAP_W, H=MAP_H.

Structure
REQ-027 Package pool_pkg SHALL hold the FSM state encoding, the default map sizes (28, 28) and the read-latency constant (1).
REQ-028 A sub-module pool_addr_gen SHALL contain the window/row/column counters and rd_addr generation; pool_ctrl SHALL own the FSM and the pool_clr/out_valid delay pipeline.

Verification
REQ-029 4x4 map, start at cycle 0 -> rd_addr 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15 in cycles 1..16; out_valid in cycles 6,10,14,18 with out_addr 0..3; done in cycle 19.
REQ-030 4x4 map, buffer returns pixel value = address, pool unit attached -> captured maxima 5,7,13,15.
REQ-031 28x28 default -> exactly 784 rd_en cycles, 196 out_valid pulses, done in cycle 787, exactly one done pulse.
REQ-032 start re-pulsed at cycles 5 and 787 of a 28x28 pass -> both ignored; no second pass starts.
REQ-033 rst_n driven low at cycle 40 of a 28x28 pass -> all outputs 0 in the same cycle; no done pulse; a fresh start then runs a full correct pass.
REQ-034 POOL_CTRL_RT_SIZE_EN defined, cfg_w=8, cfg_h=6 -> 12 windows, done in cycle 51; cfg changed mid-pass -> no effect on the current pass.
